// File: rtl/ex_alu_mdu_ctrl.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit owning HI/LO.
// MDU ops run in the background; stall is raised only for HI/LO/MDU dependants.
module ex_alu_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [2:0]       ALUCtrl,
  output logic             stall,
  output logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d, mcand_q, mcand_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, done_q, done_d;

  logic md, mf, mt, sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_nx, quot, rem;
  logic [WIDTH:0]     acc_nx, sum, shifted, diff;
  logic [2*WIDTH-1:0] prod;

  assign md = ALUOp[1] & (funct[5:2] == 4'b0110);
  assign mf = ALUOp[1] & ((funct == 6'b010000) | (funct == 6'b010010));
  assign mt = ALUOp[1] & ((funct == 6'b010001) | (funct == 6'b010011));

  always_comb begin
    ALUCtrl = 3'b000;
    if (ALUOp == 2'b00)      ALUCtrl = 3'b100;
    else if (ALUOp == 2'b01) ALUCtrl = 3'b110;
    else begin
      case (funct)
        6'b100000: ALUCtrl = 3'b100;
        6'b100001: ALUCtrl = 3'b101;
        6'b100010: ALUCtrl = 3'b110;
        6'b100100: ALUCtrl = 3'b000;
        6'b100101: ALUCtrl = 3'b001;
        6'b100111: ALUCtrl = 3'b011;
        6'b101010: ALUCtrl = 3'b010;
        default:   ALUCtrl = 3'b000;
      endcase
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = busy & valid & (md | mf | mt);
  assign mf_sel  = valid & mf;
  assign mf_data = funct[1] ? lo_q : hi_q;

  // MULT/DIV (funct[0]=0) are signed; both work on operand magnitudes.
  assign sgn   = ~funct[0];
  assign a_neg = sgn & op_a[WIDTH-1];
  assign b_neg = sgn & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum     = acc_q + {1'b0, mcand_q};
    shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};
    if (!div_q) begin
      acc_nx = q_q[0] ? {1'b0, sum[WIDTH:1]} : {1'b0, acc_q[WIDTH:1]};
      q_nx   = {(q_q[0] ? sum[0] : acc_q[0]), q_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nx = diff;
      q_nx   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = shifted;
      q_nx   = {q_q[WIDTH-2:0], 1'b0};
    end
    prod = {acc_nx[WIDTH-1:0], q_nx};
    if (negq_q) prod = -prod;
    quot = negq_q ? -q_nx : q_nx;
    rem  = negr_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;   acc_d  = acc_q;  q_d  = q_q;
    mcand_d = mcand_q;  a_d     = a_q;     div_d  = div_q;  dz_d = dz_q;
    negq_d  = negq_q;   negr_d  = negr_q;  hi_d   = hi_q;   lo_d = lo_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (valid & md & ~flush) begin
        state_d = S_RUN;
        cnt_d   = CW'(WIDTH);
        acc_d   = '0;
        q_d     = a_mag;
        mcand_d = b_mag;
        a_d     = op_a;
        div_d   = funct[1];
        dz_d    = (op_b == '0);
        negq_d  = a_neg ^ b_neg;
        negr_d  = a_neg;
      end else if (valid & mt & ~flush) begin
        if (funct[1]) lo_d = op_a;
        else          hi_d = op_a;
      end
    end else if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      acc_d = acc_nx;
      q_d   = q_nx;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  cnt_q  <= '0;  acc_q <= '0;  q_q <= '0;
      mcand_q <= '0;      a_q    <= '0;  div_q <= 1'b0; dz_q <= 1'b0;
      negq_q  <= 1'b0;    negr_q <= 1'b0; hi_q <= '0;   lo_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;  acc_q <= acc_d; q_q <= q_d;
      mcand_q <= mcand_d; a_q    <= a_d;    div_q <= div_d; dz_q <= dz_d;
      negq_q  <= negq_d;  negr_q <= negr_d; hi_q <= hi_d;   lo_q <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_ex_alu_mdu_ctrl.sv
// Directed bench for ex_alu_mdu_ctrl: MDU results go through a done-driven scoreboard,
// decode/stall/flush/MT/reset behaviour is checked inline.
module tb_ex_alu_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, valid, flush;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic [2:0]  ALUCtrl;
  logic        stall, mf_sel, busy, done;
  logic [31:0] mf_data, hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  ex_alu_mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct(funct), .valid(valid),
    .flush(flush), .op_a(op_a), .op_b(op_b), .ALUCtrl(ALUCtrl), .stall(stall),
    .mf_sel(mf_sel), .mf_data(mf_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every done pulse must match the oldest expected HI/LO.
  always @(negedge clk) begin
    if (done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done hi=%h lo=%h required=no done", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          fails++;
          $display("FAIL md_result hi=%h lo=%h required hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end else
          $display("[TB] md_result hi=%h lo=%h ok", hi, lo);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else
      $display("[TB] %s = %h ok", name, got);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; ALUOp = 2'b10; funct = f; op_a = a; op_b = b;
  endtask

  // Start an md op from IDLE, optionally scoreboard it, and measure the busy window.
  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(f, a, b);
    #1;
    check({name, "_start_stall"}, {31'd0, stall}, 32'd0);
    exp_q.push_back({eh, el});
    tick;
    valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; tick; end
    check({name, "_busy_cycles"}, n, 32'd32);
  endtask

  initial begin
    int n, bad;
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ALUOp = 2'b00; funct = 6'd0;
    op_a = '0; op_b = '0;
    tick; tick;
    rst_n = 1'b1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // ALUCtrl decode
    ALUOp = 2'b00; funct = 6'b111111; #1; check("dec_00", {29'd0, ALUCtrl}, 32'd4);
    ALUOp = 2'b01; #1;                    check("dec_01", {29'd0, ALUCtrl}, 32'd6);
    ALUOp = 2'b10; funct = 6'b100111; #1; check("dec_nor", {29'd0, ALUCtrl}, 32'd3);
    funct = 6'b101010; #1;                check("dec_slt", {29'd0, ALUCtrl}, 32'd2);
    funct = 6'b111111; #1;                check("dec_other", {29'd0, ALUCtrl}, 32'd0);
    funct = 6'b100001; #1;                check("dec_addu", {29'd0, ALUCtrl}, 32'd5);
    funct = 6'b100010; #1;                check("dec_sub", {29'd0, ALUCtrl}, 32'd6);
    ALUOp = 2'b11; funct = 6'b100101; #1; check("dec_or", {29'd0, ALUCtrl}, 32'd1);
    tick;

    // Multiply / divide results through the scoreboard
    run_md("mult_neg3x7", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    tick;
    run_md("multu_max_x2", 6'b011001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run_md("div_m7_2", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu_by0", 6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_md("div_min_m1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_md("div_7_m2", 6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_md("divu_100_7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_by0_neg", 6'b011010, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // ALU op proceeds during a run; MFLO stalls until busy falls
    issue(6'b011001, 32'd6, 32'd7);
    exp_q.push_back({32'd0, 32'd42});
    tick;
    funct = 6'b100000; #1;
    check("add_no_stall", {31'd0, stall}, 32'd0);
    check("add_aluctrl", {29'd0, ALUCtrl}, 32'd4);
    tick;
    funct = 6'b010010; #1;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (!stall) bad++;
      n++; tick;
    end
    check("mflo_stall_cycles", n, 32'd31);
    check("mflo_stall_gaps", bad, 32'd0);
    check("mflo_released", {31'd0, stall}, 32'd0);
    check("mflo_sel", {31'd0, mf_sel}, 32'd1);
    check("mflo_data", mf_data, 32'd42);
    funct = 6'b010000; #1;
    check("mfhi_data", mf_data, 32'd0);
    valid = 1'b0;
    tick;

    // Back-to-back md: second one stalls, then starts the cycle busy is low
    issue(6'b011001, 32'd3, 32'd3);
    exp_q.push_back({32'd0, 32'd9});
    tick;
    funct = 6'b011011; op_a = 32'd9; op_b = 32'd2; #1;
    n = 0;
    while (busy && n < 100) begin n++; tick; end
    check("b2b_stall_cycles", n, 32'd32);
    check("b2b_no_stall_idle", {31'd0, stall}, 32'd0);
    exp_q.push_back({32'd1, 32'd4});
    tick;
    valid = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 100) begin n++; tick; end
    check("b2b_second_cycles", n, 32'd32);

    // Flush on the 10th RUN cycle of a DIV: abort, HI/LO kept, no done
    issue(6'b011010, 32'd100, 32'd3);
    tick;
    valid = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'd1);
    check("flush_lo", lo, 32'd4);
    repeat (40) tick;
    check("flush_lo_later", lo, 32'd4);

    // Flush together with a start: no start
    issue(6'b011000, 32'd5, 32'd5);
    flush = 1'b1;
    tick;
    flush = 1'b0; valid = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // MTHI / MTLO
    issue(6'b010001, 32'h1234, 32'd0);
    tick;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, 32'd4);
    issue(6'b010011, 32'hABCD, 32'd0);
    tick;
    valid = 1'b0;
    check("mtlo_lo", lo, 32'hABCD);

    // Mid-run reset during a MULT
    issue(6'b011000, 32'd5, 32'hFFFFFFFC);
    tick;
    valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    repeat (40) tick;
    check("mrst_no_done_lo", lo, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_alu_mdu_ctrl.md
# ex_alu_mdu_ctrl

Execute-stage ALU control unit with an attached iterative multiply/divide unit (MDU) and HI/LO register pair for the pipelined MIPS core. It decodes `ALUOp`/`funct` into the 3-bit `ALUCtrl` code with the existing mapping, and adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. Multi-cycle MDU operations run in the background. The block raises `stall` only when a later instruction depends on HI/LO or the MDU.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 2. Product and quotient widths derive from it.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ALUOp`  in  2: main-decoder ALU operation class.
- `funct`  in  6: instruction funct field.
- `valid`  in  1: EX-stage instruction is real (not a bubble).
- `flush`  in  1: squash the EX instruction and abort any MDU operation.
- `op_a`  in  WIDTH: rs operand.
- `op_b`  in  WIDTH: rt operand.
- `ALUCtrl`  out  3: ALU operation code (combinational).
- `stall`  out  1: hold IF/ID/EX this cycle (combinational).
- `mf_sel`  out  1: EX result comes from `mf_data`, not the ALU.
- `mf_data`  out  WIDTH: HI for MFHI, LO for MFLO.
- `busy`  out  1: MDU operation in progress (registered).
- `done`  out  1: one-cycle pulse when HI/LO take an MDU result (registered).
- `hi`, `lo`  out  WIDTH each: architectural HI/LO (registered).

## Operation
- **ALUCtrl decode:**
  - `ALUOp`=00 → 100.
  - `ALUOp`=01 → 110.
  - `ALUOp`=1x → decode on funct: 100000→100, 100001→101, 100010→110, 100100→000, 100101→001, 100111→011, 101010→010.
  - Any other funct → 000.
- **MDU functs** (recognised only when `ALUOp`=1x):
  - Multiply/divide (md): 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Move-from (mf): 010000 MFHI, 010010 MFLO.
  - Move-to (mt): 010001 MTHI, 010011 MTLO.
- **States:**
  - IDLE → RUN when `valid & md & !flush`. Operands, signs and op type are latched on this edge; cycle counter is loaded with WIDTH.
  - RUN: one shift-add or restoring-subtract step per cycle; counter decrements. At count 1, the next edge writes HI/LO, pulses `done`, and returns to IDLE.
  - RUN → IDLE on `flush`. HI/LO are left unchanged and `done` stays 0.
- **Stall:** `stall = busy & valid & (md | mf | mt)`. ALU instructions proceed while `busy` is high.
- **Multiply:**
  - Product is the 2·WIDTH-bit value; HI = upper half, LO = lower half.
  - Signed multiply works on magnitudes and negates the product if the operand signs differ.
- **Divide:**
  - LO = quotient, HI = remainder.
  - Signed divide works on magnitudes. Quotient is negative iff signs differ; remainder takes the sign of `op_a`.
  - Divide by zero (either flavour): HI = `op_a`, LO = all ones.
  - Signed MIN / −1: LO = MIN, HI = 0, with no exception.
- **MT:** when `valid & mt & !busy & !flush`, the next edge writes `op_a` into HI or LO.
- **MF:** `mf_sel = valid & mf & !ALUOp[1]==0`. `mf_data` shows the current `hi`/`lo` combinationally.
- **Reset** (`rst_n`=0 at an edge) overrides everything:
  - state = IDLE, counter = 0.
  - `hi` = `lo` = 0.
  - `busy` = `done` = 0.
  - A run in progress is discarded.
- **Priority:** reset > flush > start/MT. A flush in the same cycle as a start means no start.

## Timing
- The start instruction leaves EX on its own cycle; it never stalls itself.
- `busy` = 1 for exactly WIDTH cycles after the start edge.
- Result edge is the WIDTH-th edge after start. On that edge `hi`/`lo` update, `busy` falls and `done` = 1 for one cycle.
- An MF waiting on `stall` reads the new value in the cycle `busy` is 0. Total MDU-to-MF latency is WIDTH+1 cycles.
- Back-to-back md: the second one stalls until `busy` = 0, then starts on that cycle. There is no idle gap beyond that.
- The counter is ⌈log2(WIDTH+1)⌉ bits wide. Internal remainder/accumulator is WIDTH+1 bits.

## Test plan
- **ALUCtrl decode:**
  - `ALUOp`=00 → 100.
  - `ALUOp`=01 → 110.
  - `ALUOp`=10 with funct 100111 → 011; with 101010 → 010; with 111111 → 000.
- **Multiply** (WIDTH=32):
  - MULT 0xFFFFFFFD × 7 → `busy` high for 32 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, `done` pulses once.
  - MULTU 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE.
- **Divide:**
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 → HI = 7, LO = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Stall behaviour:**
  - MFLO valid during a run → `stall` = 1 every cycle until `busy` falls; then `mf_data` = the new LO.
  - ADD valid during a run → `stall` = 0.
- **Flush and MT:**
  - `flush` on the 10th RUN cycle of a DIV → `busy` = 0 next cycle, HI/LO hold their previous values, no `done`.
  - MTHI with `op_a` = 0x1234 in IDLE → `hi` = 0x1234 after the next edge.
- **Mid-run reset:** `rst_n` = 0 for one edge during a MULT → `busy` = 0, `hi` = `lo` = 0, no `done`.
